// File: rtl/counter_programmer.sv
// counter_programmer
//   Programs an external counter over an 8-bit bidirectional bus, verifies it, then starts it.
//   Sequence: capture config, range-check, write PLR/ULR/LLR/CCR, poll err, read the four
//   registers back and compare, pulse start_in, then wait for ec under a watchdog.
//
// Ports
//   clk, reset          : clock (posedge) and asynchronous active-low reset
//   cfg_valid/cfg_ready : configuration handshake, accepted when both are high on a posedge
//   cfg_plr/ulr/llr/ccr : preload, upper, lower limit and cycle count, captured at accept
//   Din                 : counter data bus, driven only while writing
//   ncs, nrd, nwr       : active-low chip-select, read and write strobes
//   A1, A0              : register select, 00=PLR 01=ULR 10=LLR 11=CCR
//   start_in            : one-cycle start pulse to the counter
//   err, ec             : counter error and end-of-cycle inputs
//   busy, done, fail    : status; done/fail are one-cycle pulses
//   fail_code           : abort cause, held until the next accept
//                         001=range 010=readback 011=counter err 100=timeout

module counter_programmer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_plr,
  input  logic [7:0] cfg_ulr,
  input  logic [7:0] cfg_llr,
  input  logic [7:0] cfg_ccr,
  inout  wire  [7:0] Din,
  output logic       ncs,
  output logic       nrd,
  output logic       nwr,
  output logic       A1,
  output logic       A0,
  output logic       start_in,
  input  logic       err,
  input  logic       ec,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [2:0] fail_code
);

  typedef enum logic [3:0] {
    StIdle,
    StCheck,
    StWr,
    StErrChk,
    StRd,
    StStart,
    StRun,
    StDone,
    StFail
  } state_e;

  localparam logic [15:0] WdogLast = 16'(TIMEOUT - 1);

  localparam logic [2:0] CodeRange    = 3'b001;
  localparam logic [2:0] CodeReadback = 3'b010;
  localparam logic [2:0] CodeErr      = 3'b011;
  localparam logic [2:0] CodeTimeout  = 3'b100;

  state_e      state_q;
  logic [7:0]  cfg_q [4];   // indexed by register select
  logic [1:0]  idx_q;       // register currently written/read
  logic [1:0]  ph_q;        // phase within the three-cycle bus access
  logic [15:0] wdog_q;
  logic        mis_q;       // readback mismatch seen for the current register
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic        fail_q;
  logic [2:0]  code_q;
  logic        ncs_q;
  logic        nrd_q;
  logic        nwr_q;
  logic [1:0]  a_q;
  logic        start_q;
  logic        doe_q;
  logic [7:0]  dout_q;

  logic        range_ok;
  logic        go_fail;
  logic [2:0]  go_code;
  logic [1:0]  idx_nxt;

  assign range_ok = (cfg_q[2] <= cfg_q[0]) && (cfg_q[0] <= cfg_q[1]) && (cfg_q[3] != 8'd0);
  assign idx_nxt  = idx_q + 2'd1;

  // Abort decisions. Written as if/else on err/ec so that an undriven (Z/X) input takes the
  // "not asserted" branch.
  always_comb begin
    go_fail = 1'b0;
    go_code = 3'b000;
    unique case (state_q)
      StCheck: begin
        if (!range_ok) begin
          go_fail = 1'b1;
          go_code = CodeRange;
        end
      end
      StErrChk: begin
        if (err) begin
          go_fail = 1'b1;
          go_code = CodeErr;
        end
      end
      StRd: begin
        if (ph_q == 2'd2 && mis_q) begin
          go_fail = 1'b1;
          go_code = CodeReadback;
        end
      end
      StRun: begin
        if (ec) begin
          go_fail = 1'b0;   // end-of-cycle beats both err and timeout
        end else if (err) begin
          go_fail = 1'b1;
          go_code = CodeErr;
        end else if (wdog_q == WdogLast) begin
          go_fail = 1'b1;
          go_code = CodeTimeout;
        end
      end
      default: begin
        go_fail = 1'b0;
      end
    endcase
  end

  // All outputs are set on the edge that enters the state they belong to, so every output
  // is a flop and valid for the whole cycle of that state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      for (int i = 0; i < 4; i++) begin
        cfg_q[i] <= 8'h00;
      end
      idx_q   <= 2'd0;
      ph_q    <= 2'd0;
      wdog_q  <= 16'd0;
      mis_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= 3'b000;
      ncs_q   <= 1'b1;
      nrd_q   <= 1'b1;
      nwr_q   <= 1'b1;
      a_q     <= 2'd0;
      start_q <= 1'b0;
      doe_q   <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      start_q <= 1'b0;
      if (go_fail) begin
        state_q <= StFail;
        fail_q  <= 1'b1;
        code_q  <= go_code;
        ncs_q   <= 1'b1;
        nrd_q   <= 1'b1;
        nwr_q   <= 1'b1;
        a_q     <= 2'd0;
        doe_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cfg_valid) begin
              cfg_q[0] <= cfg_plr;
              cfg_q[1] <= cfg_ulr;
              cfg_q[2] <= cfg_llr;
              cfg_q[3] <= cfg_ccr;
              code_q   <= 3'b000;
              ready_q  <= 1'b0;
              busy_q   <= 1'b1;
              state_q  <= StCheck;
            end
          end
          StCheck: begin
            state_q <= StWr;
            idx_q   <= 2'd0;
            ph_q    <= 2'd0;
            ncs_q   <= 1'b0;
            a_q     <= 2'd0;
            doe_q   <= 1'b1;
            dout_q  <= cfg_q[0];
          end
          StWr: begin
            unique case (ph_q)
              2'd0: begin
                nwr_q <= 1'b0;
                ph_q  <= 2'd1;
              end
              2'd1: begin
                nwr_q <= 1'b1;
                ph_q  <= 2'd2;
              end
              default: begin
                ph_q <= 2'd0;
                if (idx_q == 2'd3) begin
                  state_q <= StErrChk;
                  doe_q   <= 1'b0;
                end else begin
                  idx_q  <= idx_nxt;
                  a_q    <= idx_nxt;
                  dout_q <= cfg_q[idx_nxt];
                end
              end
            endcase
          end
          StErrChk: begin
            state_q <= StRd;
            idx_q   <= 2'd0;
            ph_q    <= 2'd0;
            a_q     <= 2'd0;
            nrd_q   <= 1'b0;
            mis_q   <= 1'b0;
          end
          StRd: begin
            unique case (ph_q)
              2'd0: begin
                ph_q <= 2'd1;
              end
              2'd1: begin
                // Counter has had two cycles to drive the bus; sample at the end of the second.
                mis_q <= (Din != cfg_q[idx_q]);
                nrd_q <= 1'b1;
                ph_q  <= 2'd2;
              end
              default: begin
                ph_q <= 2'd0;
                if (idx_q == 2'd3) begin
                  state_q <= StStart;
                  start_q <= 1'b1;
                end else begin
                  idx_q <= idx_nxt;
                  a_q   <= idx_nxt;
                  nrd_q <= 1'b0;
                end
              end
            endcase
          end
          StStart: begin
            state_q <= StRun;
            wdog_q  <= 16'd0;
          end
          StRun: begin
            if (ec) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              ncs_q   <= 1'b1;
            end else begin
              wdog_q <= wdog_q + 16'd1;
            end
          end
          StDone, StFail: begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  // ready_q is already 1 while held in reset; gating with reset keeps cfg_ready low during
  // reset yet high on the very first edge after release.
  assign cfg_ready = ready_q & reset;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_code = code_q;
  assign ncs       = ncs_q;
  assign nrd       = nrd_q;
  assign nwr       = nwr_q;
  assign A1        = a_q[1];
  assign A0        = a_q[0];
  assign start_in  = start_q;
  assign Din       = doe_q ? dout_q : 8'hzz;

endmodule

// File: tb/tb_counter_programmer.sv
// Directed bench for counter_programmer: one default instance driven through nominal,
// boundary, range, readback, err and reset scenarios, plus a TIMEOUT=16 instance for the
// watchdog. Each instance has a small echo model of the counter's register file.

module tb_counter_programmer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cfg_valid, cfg_valid_t;
  logic [7:0] plr, ulr, llr, ccr;
  logic       err, ec, err_t, ec_t;
  logic       bad_ulr, tb_drv;

  wire  [7:0] din0, din1;
  logic       cfg_ready, ncs, nrd, nwr, A1, A0, start_in, busy, done, fail;
  logic [2:0] fail_code;
  logic       cfg_ready_t, ncs_t, nrd_t, nwr_t, A1_t, A0_t, start_t, busy_t, done_t, fail_t;
  logic [2:0] code_t;

  logic [7:0] mem0 [4];
  logic [7:0] mem1 [4];

  counter_programmer dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_plr(plr), .cfg_ulr(ulr), .cfg_llr(llr), .cfg_ccr(ccr), .Din(din0),
    .ncs(ncs), .nrd(nrd), .nwr(nwr), .A1(A1), .A0(A0), .start_in(start_in),
    .err(err), .ec(ec), .busy(busy), .done(done), .fail(fail), .fail_code(fail_code)
  );

  counter_programmer #(.TIMEOUT(16)) dut_t (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid_t), .cfg_ready(cfg_ready_t),
    .cfg_plr(plr), .cfg_ulr(ulr), .cfg_llr(llr), .cfg_ccr(ccr), .Din(din1),
    .ncs(ncs_t), .nrd(nrd_t), .nwr(nwr_t), .A1(A1_t), .A0(A0_t), .start_in(start_t),
    .err(err_t), .ec(ec_t), .busy(busy_t), .done(done_t), .fail(fail_t), .fail_code(code_t)
  );

  // Counter models: latch writes, echo on read. bad_ulr corrupts ULR reads; tb_drv puts a
  // marker on the bus to show the DUT has released it.
  assign din0 = tb_drv ? 8'hA5 :
                (!ncs && !nrd) ? ((bad_ulr && {A1, A0} == 2'd1) ? 8'h00 : mem0[{A1, A0}]) :
                8'hzz;
  assign din1 = (!ncs_t && !nrd_t) ? mem1[{A1_t, A0_t}] : 8'hzz;

  always @(posedge clk) begin
    if (!ncs && !nwr) mem0[{A1, A0}] <= din0;
    if (!ncs_t && !nwr_t) mem1[{A1_t, A0_t}] <= din1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, start_hi, start_at, done_cnt, fail_cnt, overlap, ncs_low, nrd_low, nwr_low;
  logic [9:0] wr_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the middle (negedge) of cycle n, with cycle 0 ending at the accepting posedge.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
      if (start_in) begin
        start_hi++;
        start_at = cyc;
      end
      if (done) done_cnt++;
      if (fail) fail_cnt++;
      if (!nrd && !nwr) overlap++;
      if (!ncs) ncs_low++;
      if (!nrd) nrd_low++;
      if (!nwr) begin
        nwr_low++;
        wr_log.push_back({A1, A0, din0});
      end
    end
  endtask

  task automatic start_run(input logic [7:0] p, input logic [7:0] u, input logic [7:0] l,
                           input logic [7:0] c);
    plr = p; ulr = u; llr = l; ccr = c;
    cfg_valid = 1'b1;
    cyc = 0; start_hi = 0; start_at = 0; done_cnt = 0; fail_cnt = 0;
    overlap = 0; ncs_low = 0; nrd_low = 0; nwr_low = 0;
    wr_log.delete();
    goto(1);
    cfg_valid = 1'b0;
  endtask

  task automatic run_nominal(input string tag);
    logic [9:0] exp_w [4];
    exp_w[0] = {2'd0, 8'h05};
    exp_w[1] = {2'd1, 8'h08};
    exp_w[2] = {2'd2, 8'h03};
    exp_w[3] = {2'd3, 8'h01};
    start_run(8'h05, 8'h08, 8'h03, 8'h01);
    chk({tag, "_c1_busy"}, {busy, cfg_ready, fail_code}, 5'b10_000);
    goto(2);
    chk({tag, "_c2_setup"}, {ncs, nwr, nrd, A1, A0}, 5'b01100);
    chk({tag, "_c2_din"}, din0, 8'h05);
    // Attempt a re-configuration while busy; it must be ignored.
    cfg_valid = 1'b1;
    llr = 8'hEE;
    goto(3);
    chk({tag, "_c3_strobe"}, nwr, 1'b0);
    cfg_valid = 1'b0;
    goto(14);
    chk({tag, "_c14_errchk"}, {ncs, nwr, nrd}, 3'b011);
    goto(15);
    chk({tag, "_c15_rd"}, {nrd, A1, A0}, 3'b000);
    chk({tag, "_c15_din"}, din0, 8'h05);
    goto(27);
    chk({tag, "_c27_start"}, start_in, 1'b1);
    goto(40);
    chk({tag, "_c40_run"}, {ncs, busy}, 2'b01);
    goto(67);
    ec = 1'b1;
    goto(68);
    ec = 1'b0;
    chk({tag, "_c68_done"}, {done, fail, ncs}, 3'b101);
    goto(69);
    chk({tag, "_c69_idle"}, {done, busy, cfg_ready, fail_code}, 6'b001_000);
    chk({tag, "_wr_count"}, 32'(wr_log.size()), 4);
    for (int i = 0; i < wr_log.size() && i < 4; i++) begin
      chk({tag, "_wr_entry"}, wr_log[i], exp_w[i]);
    end
    chk({tag, "_start_pulses"}, start_hi, 1);
    chk({tag, "_start_cycle"}, start_at, 27);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_fail_pulses"}, fail_cnt, 0);
    chk({tag, "_rd_wr_overlap"}, overlap, 0);
  endtask

  initial begin
    reset = 1'b0;
    cfg_valid = 1'b0; cfg_valid_t = 1'b0;
    plr = 8'h00; ulr = 8'h00; llr = 8'h00; ccr = 8'h00;
    err = 1'b0; ec = 1'b0; err_t = 1'b0; ec_t = 1'bz;
    bad_ulr = 1'b0; tb_drv = 1'b1;
    cyc = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_outputs", {ncs, nrd, nwr, A1, A0, start_in, busy, done, fail, fail_code}, 12'hE00);
    chk("rst_cfg_ready", cfg_ready, 1'b0);
    chk("rst_din_released", din0, 8'hA5);
    reset = 1'b1;
    tb_drv = 1'b0;
    #1;
    chk("rel_cfg_ready", cfg_ready, 1'b1);

    // Nominal, accepted on the first edge after release.
    run_nominal("nom");

    // Range failure: plr above ulr.
    start_run(8'h09, 8'h08, 8'h03, 8'h01);
    goto(2);
    chk("range_c2_fail", {fail, fail_code, ncs}, 5'b1_001_1);
    goto(3);
    chk("range_c3_idle", {fail, busy, fail_code}, 5'b00_001);
    chk("range_no_bus", ncs_low + nwr_low, 0);

    // Boundary: cycle count of zero is a range failure.
    start_run(8'h05, 8'h08, 8'h03, 8'h00);
    goto(2);
    chk("ccr0_c2_fail", {fail, fail_code, ncs}, 5'b1_001_1);
    goto(3);

    // Boundary: llr == plr == ulr is in range.
    start_run(8'h07, 8'h07, 8'h07, 8'hFF);
    chk("eq_c1_code_cleared", fail_code, 3'b000);
    goto(2);
    chk("eq_c2_wr", {ncs, fail}, 2'b00);
    goto(30);
    ec = 1'b1;
    goto(31);
    ec = 1'b0;
    chk("eq_c31_done", {done, fail}, 2'b10);
    goto(32);

    // Readback mismatch on ULR.
    bad_ulr = 1'b1;
    start_run(8'h05, 8'h08, 8'h03, 8'h01);
    goto(20);
    chk("rb_c20_turnaround", {fail, busy, nrd}, 3'b011);
    goto(21);
    chk("rb_c21_fail", {fail, fail_code, ncs}, 5'b1_010_1);
    goto(22);
    chk("rb_c22_idle", {busy, fail_code}, 4'b0_010);
    chk("rb_no_start", start_hi, 0);
    bad_ulr = 1'b0;

    // Counter err during ERRCHK.
    start_run(8'h05, 8'h08, 8'h03, 8'h01);
    chk("err_c1_code_cleared", fail_code, 3'b000);
    goto(14);
    err = 1'b1;
    goto(15);
    err = 1'b0;
    chk("err_c15_fail", {fail, fail_code, nrd, ncs}, 6'b1_011_11);
    goto(16);
    chk("err_no_rd", nrd_low, 0);

    // Watchdog on the TIMEOUT=16 instance; its ec is left undriven.
    plr = 8'h05; ulr = 8'h08; llr = 8'h03; ccr = 8'h01;
    cfg_valid_t = 1'b1;
    cyc = 0;
    goto(1);
    cfg_valid_t = 1'b0;
    goto(27);
    chk("to_c27_start", start_t, 1'b1);
    goto(43);
    chk("to_c43_running", {fail_t, busy_t, ncs_t}, 3'b010);
    goto(44);
    chk("to_c44_fail", {fail_t, code_t, ncs_t}, 5'b1_100_1);
    goto(45);
    chk("to_c45_idle", {busy_t, cfg_ready_t}, 2'b01);

    // Reset in the middle of WR (ULR hold cycle).
    start_run(8'h05, 8'h08, 8'h03, 8'h01);
    goto(7);
    chk("mid_c7_hold", {ncs, nwr, A1, A0}, 4'b0101);
    chk("mid_c7_din", din0, 8'h08);
    reset = 1'b0;
    tb_drv = 1'b1;
    #1;
    chk("mid_rst_outputs",
        {ncs, nrd, nwr, A1, A0, start_in, busy, done, fail, fail_code}, 12'hE00);
    chk("mid_rst_cfg_ready", cfg_ready, 1'b0);
    chk("mid_rst_din", din0, 8'hA5);
    @(negedge clk);
    reset = 1'b1;
    tb_drv = 1'b0;
    #1;
    chk("mid_rel_cfg_ready", cfg_ready, 1'b1);
    run_nominal("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_programmer.md
COUNTER_PROGRAMMER -- requirements
Module: counter_programmer

Interface
REQ-001 Parameter: TIMEOUT, 1024, maximum clk cycles spent in RUN waiting for ec before abort.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cfg_valid  input  1  configuration request.
REQ-005 cfg_ready  output  1  high only in IDLE; a request is accepted on a posedge with cfg_valid=1 and cfg_ready=1.
REQ-006 cfg_plr, cfg_ulr, cfg_llr, cfg_ccr  input  8 each  preload, upper-limit, lower-limit and cycle-count values, captured at accept.
REQ-007 Din  inout  8  counter data bus; driven only in WR states, Z otherwise.
REQ-008 ncs, nrd, nwr  output  1 each  active-low counter chip-select, read and write strobes.
REQ-009 A1, A0  output  1 each  counter register select: 00=PLR, 01=ULR, 10=LLR, 11=CCR.
REQ-010 start_in  output  1  start pulse to the counter.
REQ-011 err, ec  input  1 each  counter error and end-of-cycle; Z or X is treated as 0.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on successful completion.
REQ-014 fail  output  1  one-cycle pulse on abort.
REQ-015 fail_code  output  3  abort cause, held until the next accept: 001=range, 010=readback mismatch, 011=counter err, 100=timeout.

Function
REQ-016 All outputs are registered; the FSM states are IDLE, CHECK, WR, ERRCHK, RD, START, RUN, DONE and FAIL.
REQ-017 IDLE: on accept, capture the four cfg values and go to CHECK.
REQ-018 CHECK (1 cycle): go to WR if llr<=plr<=ulr (unsigned) and ccr!=0; otherwise go to FAIL with code 001 and no bus activity, so ncs stays 1.
REQ-019 WR: four registers in order 00,01,10,11, three cycles each:
- setup: A1A0 and Din valid, nwr=1
- strobe: nwr=0
- hold: nwr=1, Din still driven
REQ-020 ncs goes low on the first WR cycle and stays low through RUN.
REQ-021 ERRCHK (1 cycle): go to FAIL with code 011 if err=1 is sampled; otherwise go to RD.
REQ-022 RD: four registers in order 00..11, three cycles each:
- cycles 1-2: nrd=0, Din released
- Din is sampled at the posedge ending cycle 2
- cycle 3: nrd=1 turnaround
REQ-023 The first RD mismatch against the captured value goes to FAIL with code 010 after that register's turnaround cycle; no start pulse is issued.
REQ-024 nrd and nwr are never low in the same cycle; Din is never driven while nrd=0.
REQ-025 START: start_in=1 for exactly one clk period, then go to RUN.
REQ-026 RUN: an 16-bit watchdog counts cycles.
- ec=1 sampled -> DONE.
- watchdog reaches TIMEOUT -> FAIL with code 100.
- If ec=1 and timeout occur in the same cycle, ec wins.
REQ-027 err=1 sampled during RUN -> FAIL with code 011.
REQ-028 DONE (1 cycle): done=1, ncs=1, then IDLE.
REQ-029 FAIL (1 cycle): fail=1, ncs=1, nrd=1, nwr=1, start_in=0, then IDLE.
REQ-030 Cycle timing, with accept at posedge 0:
- CHECK: cycle 1
- WR: cycles 2-13
- ERRCHK: cycle 14
- RD: cycles 15-26
- START: cycle 27
- RUN: from cycle 28
REQ-031 cfg_valid is ignored while busy=1; inputs are not re-captured.

Reset
REQ-032 reset=0 asynchronously forces the following, regardless of state (including mid-WR or mid-RD):
- state IDLE
- ncs=1, nrd=1, nwr=1, A1=0, A0=0, start_in=0
- Din=Z
- busy=0, done=0, fail=0, fail_code=000
- watchdog=0
- cfg_ready=0 while reset=0 and 1 after release.
REQ-033 The first accept is possible on the first posedge after reset release.

Verification
REQ-034 Nominal: plr=05, ulr=08, llr=03, ccr=01; the counter model echoes writes and asserts ec 40 cycles after start.
- Writes appear as 00:05, 01:08, 10:03, 11:01.
- start_in is high in cycle 27 only.
- done pulses once, fail=0, fail_code=000.
REQ-035 Range: plr=09, ulr=08 -> fail pulse at cycle 2, fail_code=001, ncs=1 throughout.
REQ-036 Readback: the model returns 00 for ULR -> fail_code=010, start_in never high, ncs=1 after FAIL.
REQ-037 Timeout: TIMEOUT=16 and ec held 0 -> fail_code=100 after 16 RUN cycles.
REQ-038 Counter err: err=1 in ERRCHK -> fail_code=011, no RD cycles.
REQ-039 Reset pulse during WR cycle 7 -> all outputs idle within the same cycle, Din=Z, cfg_ready=1 after release, and a new nominal run then completes.
